// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Serial WIDTH-bit add/subtract sequencer. One 4-bit ripple slice is reused
//   once per clock, LSB nibble first. Operands come in over a valid/ready
//   handshake. The result goes out over a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   requester presents an operation
//   in_ready   controller is idle and can accept an operation
//   op         0 = add (a+b+cin), 1 = subtract (a-b, cin ignored)
//   a, b       operands (WIDTH bits)
//   cin        carry-in for add
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   sum        result (WIDTH bits), registered
//   cout       final carry; for subtract 1 = no borrow
//   busy       operation in flight or result pending
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_q, cout_q;
  logic [CW-1:0]    n_q;

  logic [3:0] nib_a, nib_b, slice_s;
  logic [4:0] carry;
  logic       slice_c;
  logic       last;

  assign last = (n_q == CW'(NIB - 1));

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (n_q == CW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // 4-bit ripple-carry slice; purely combinational.
  always_comb begin
    carry    = '0;
    slice_s  = '0;
    carry[0] = c_q;
    for (int unsigned i = 0; i < 4; i++) begin
      slice_s[i]  = nib_a[i] ^ nib_b[i] ^ carry[i];
      carry[i+1]  = (nib_a[i] & nib_b[i]) | (carry[i] & (nib_a[i] ^ nib_b[i]));
    end
    slice_c = carry[4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      n_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            // Subtract is a + ~b + 1, so invert b here and force carry-in.
            b_q    <= op ? ~b : b;
            c_q    <= op | cin;
            n_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIB; i++) begin
            if (n_q == CW'(i)) sum_q[4*i +: 4] <= slice_s;
          end
          c_q <= slice_c;
          if (last) begin
            n_q    <= '0;
            cout_q <= slice_c;
          end else begin
            n_q <= n_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid, in_ready, op, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;

  // 4-bit instance
  logic       in_valid4, in_ready4, op4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0] a4, b4, sum4;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op4), .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] es;
    logic        ec;
  } vec_t;

  vec_t vecs[10];

  // Full transaction on the 16-bit instance with a fixed cycle schedule.
  // Inputs change #1 after each rising edge; outputs are sampled there too.
  task automatic run_op(input vec_t v);
    check({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b; cin = v.cin;
    @(posedge clk); #1;                       // handshake edge k
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = ~v.op; cin = ~v.cin;
    for (int i = 1; i <= 4; i++) begin
      check({v.name, " in_ready run"}, 32'(in_ready), 32'd0);
      check({v.name, " busy run"}, 32'(busy), 32'd1);
      check({v.name, " out_valid run"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;                     // edge k+i
    end
    check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
    check({v.name, " sum"}, 32'(sum), 32'(v.es));
    check({v.name, " cout"}, 32'(cout), 32'(v.ec));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, " out_valid after accept"}, 32'(out_valid), 32'd0);
    check({v.name, " in_ready after accept"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{"add_basic",   1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{"add_wrap",    1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{"add_ripple",  1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[3] = '{"sub_borrow",  1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0};
    vecs[4] = '{"sub_cin_ign", 1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1};
    vecs[5] = '{"add_max",     1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{"sub_equal",   1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{"add_zero",    1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[8] = '{"sub_under",   1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0};
    vecs[9] = '{"add_alt",     1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; op4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst4 out_valid", 32'(out_valid4), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Backpressure: result held in DONE while inputs churn.
    in_valid = 1'b1; op = 1'b0; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp sum", 32'(sum), 32'h0100);
      check("bp cout", 32'(cout), 32'd0);
    end
    out_ready = 1'b1; op = 1'b0; a = 16'h0100; b = 16'h0023; cin = 1'b0;
    @(posedge clk); #1;                       // accept edge; in_valid ignored here
    out_ready = 1'b0;
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    check("bp idle out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;                       // capture edge
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    check("bp capture busy", 32'(busy), 32'd1);
    check("bp capture in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("bp next out_valid", 32'(out_valid), 32'd1);
    check("bp next sum", 32'(sum), 32'h0123);
    check("bp next cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the 2nd RUN cycle.
    in_valid = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h1111; cin = 1'b0;
    @(posedge clk); #1;                       // edge k
    in_valid = 1'b0;
    @(posedge clk); #1;                       // edge k+1: nibble 0 written
    check("mid partial sum", 32'(sum), 32'h0002);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid rst sum", 32'(sum), 32'd0);
    check("mid rst cout", 32'(cout), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid rst no out_valid", 32'(out_valid), 32'd0);
    end

    // WIDTH=4: single RUN cycle.
    in_valid4 = 1'b1; op4 = 1'b0; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    check("w4 busy", 32'(busy4), 32'd1);
    check("w4 out_valid early", 32'(out_valid4), 32'd0);
    @(posedge clk); #1;
    check("w4 out_valid", 32'(out_valid4), 32'd1);
    check("w4 sum", 32'(sum4), 32'h1);
    check("w4 cout", 32'(cout4), 32'd1);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("w4 in_ready", 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; op4 = 1'b1; a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    check("w4 sub out_valid", 32'(out_valid4), 32'd1);
    check("w4 sub sum", 32'(sum4), 32'hE);
    check("w4 sub cout", 32'(cout4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
